// File: rtl/msg_pkg.sv
// Shared state codes, character codes and message tables for the message display.
package msg_pkg;

  typedef logic [5:0] ch_t;

  typedef enum logic [3:0] {
    ST_WELCOME = 4'd0,
    ST_GAME    = 4'd1,
    ST_SCORE   = 4'd2,
    ST_ERROR   = 4'd3,
    ST_COIN    = 4'd4,
    ST_PASS    = 4'd5,
    ST_LOSE    = 4'd6
  } state_e;

  localparam ch_t CH_A = 6'd10, CH_C = 6'd12, CH_E = 6'd14, CH_H = 6'd17, CH_I = 6'd18;
  localparam ch_t CH_L = 6'd21, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25, CH_R = 6'd27;
  localparam ch_t CH_S = 6'd28, CH_BLANK = 6'd36;

  // Tables padded to 8 entries so a 3-bit index is always in range.
  localparam ch_t MSG_HELLO [8] = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_BLANK, CH_BLANK};
  localparam ch_t MSG_ERROR [8] = '{CH_E, CH_R, CH_R, CH_O, CH_R, CH_BLANK, CH_BLANK, CH_BLANK};
  localparam ch_t MSG_COIN  [8] = '{CH_C, CH_O, CH_I, CH_N, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
  localparam ch_t MSG_PASS  [8] = '{CH_P, CH_A, CH_S, CH_S, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
  localparam ch_t MSG_LOSE  [8] = '{CH_L, CH_O, CH_S, CH_E, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};

  function automatic logic [2:0] msg_len(input logic [3:0] st);
    case (st)
      ST_WELCOME: msg_len = 3'd5;
      ST_ERROR:   msg_len = 3'd5;
      ST_COIN:    msg_len = 3'd4;
      ST_PASS:    msg_len = 3'd4;
      ST_LOSE:    msg_len = 3'd4;
      default:    msg_len = 3'd0;
    endcase
  endfunction

  function automatic ch_t msg_char(input logic [3:0] st, input logic [2:0] idx);
    case (st)
      ST_WELCOME: msg_char = MSG_HELLO[idx];
      ST_ERROR:   msg_char = MSG_ERROR[idx];
      ST_COIN:    msg_char = MSG_COIN[idx];
      ST_PASS:    msg_char = MSG_PASS[idx];
      ST_LOSE:    msg_char = MSG_LOSE[idx];
      default:    msg_char = CH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational lookup: message, scanned digit and scroll offset to a character code.
module msg_rom
  import msg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  localparam int DIG_W = $clog2(NUM_DIGITS)
) (
  input  logic [3:0]       state_i,
  input  logic [DIG_W-1:0] refresh_i,
  input  logic [2:0]       offset_i,
  input  logic             blank_i,
  output ch_t              char_o
);

  logic [2:0] len_s;
  logic [4:0] len5_s;
  logic [4:0] rel_s;
  logic [4:0] pos_s;

  // Position within the message: static when it fits, else cyclic over message + one blank.
  always_comb begin
    len_s  = msg_len(state_i);
    len5_s = 5'(len_s);
    rel_s  = 5'(NUM_DIGITS - 1) - 5'(refresh_i);
    pos_s  = rel_s;
    char_o = CH_BLANK;
    if (blank_i || (len_s == 3'd0) || (5'(refresh_i) >= 5'(NUM_DIGITS))) begin
      char_o = CH_BLANK;
    end else if (len5_s <= 5'(NUM_DIGITS)) begin
      pos_s = rel_s;
      if (pos_s < len5_s) char_o = msg_char(state_i, pos_s[2:0]);
      else                char_o = CH_BLANK;
    end else begin
      pos_s = 5'(offset_i) + rel_s;
      if (pos_s > len5_s) pos_s = pos_s - (len5_s + 5'd1);
      else                pos_s = pos_s;
      if (pos_s == len5_s) char_o = CH_BLANK;
      else                 char_o = msg_char(state_i, pos_s[2:0]);
    end
  end

endmodule

// File: rtl/msg_display.sv
// Scanned-digit message display: scroll offset, blink phase and registered character output.
module msg_display
  import msg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit BLINK_EN   = 1'b1,
  parameter int BLINK_DIV  = 4,
  localparam int DIG_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cur_state,
  input  logic             ref_sign,
  input  logic [DIG_W-1:0] refresh,
  input  logic             scroll_tick,
  output logic [5:0]       char_code,
  output logic             msg_active
);

  logic [3:0] state_q;
  logic [2:0] offset_q, offset_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       blink_off_q, blink_off_d;
  ch_t        char_q, char_d, char_code_q;
  logic       msg_active_q;
  logic [2:0] len_s;
  logic       blink_state_s;
  ch_t        rom_char_s;

  msg_rom #(.NUM_DIGITS(NUM_DIGITS)) u_rom (
    .state_i  (cur_state),
    .refresh_i(refresh),
    .offset_i (offset_q),
    .blank_i  (blink_off_q && blink_state_s),
    .char_o   (rom_char_s)
  );

  // Next-state for scroll offset, blink divider and character capture.
  always_comb begin
    len_s         = msg_len(cur_state);
    blink_state_s = BLINK_EN && ((cur_state == ST_ERROR) || (cur_state == ST_LOSE));
    offset_d      = offset_q;
    blink_cnt_d   = blink_cnt_q;
    blink_off_d   = blink_off_q;
    if (cur_state != state_q) begin
      offset_d    = 3'd0;
      blink_cnt_d = 4'd0;
      blink_off_d = 1'b0;
    end else if (scroll_tick) begin
      if (int'(len_s) > NUM_DIGITS) offset_d = (offset_q == len_s) ? 3'd0 : offset_q + 3'd1;
      else                          offset_d = offset_q;
      if (blink_state_s) begin
        if (blink_cnt_q == 4'(BLINK_DIV - 1)) begin
          blink_cnt_d = 4'd0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 4'd1;
        end
      end else begin
        blink_cnt_d = blink_cnt_q;
      end
    end else begin
      offset_d = offset_q;
    end
    if (ref_sign) char_d = rom_char_s;
    else          char_d = char_q;
  end

  // State registers and the two-stage character pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= 4'd0;
      offset_q     <= 3'd0;
      blink_cnt_q  <= 4'd0;
      blink_off_q  <= 1'b0;
      char_q       <= CH_BLANK;
      char_code_q  <= CH_BLANK;
      msg_active_q <= 1'b0;
    end else begin
      state_q      <= cur_state;
      offset_q     <= offset_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      char_q       <= char_d;
      char_code_q  <= char_q;
      msg_active_q <= (len_s != 3'd0);
    end
  end

  assign char_code  = char_code_q;
  assign msg_active = msg_active_q;

endmodule

// File: tb/tb_msg_display.sv
// Scoreboard bench for msg_display: a 4-digit instance plus a 6-digit one for out-of-range refresh.
module tb_msg_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cur_state = 4'd0;
  logic       ref_sign = 1'b0;
  logic       scroll_tick = 1'b0;
  logic [1:0] refresh = 2'd0;
  logic [2:0] refresh6 = 3'd0;
  logic [5:0] char_code, char_code6;
  logic       msg_active, msg_active6;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] e1;
    logic       c2;
    logic [5:0] e2;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  msg_display #(.NUM_DIGITS(4), .BLINK_EN(1'b1), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cur_state(cur_state), .ref_sign(ref_sign),
    .refresh(refresh), .scroll_tick(scroll_tick), .char_code(char_code), .msg_active(msg_active)
  );

  msg_display #(.NUM_DIGITS(6), .BLINK_EN(1'b1), .BLINK_DIV(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .cur_state(cur_state), .ref_sign(ref_sign),
    .refresh(refresh6), .scroll_tick(scroll_tick), .char_code(char_code6), .msg_active(msg_active6)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] r, input int e1,
                        input logic c2 = 1'b0, input logic [2:0] r2 = 3'd0, input int e2 = 0);
    exp_t t;
    t.e1 = e1[5:0];
    t.c2 = c2;
    t.e2 = e2[5:0];
    exp_q.push_back(t);
    ref_sign = 1'b1;
    refresh  = r;
    refresh6 = r2;
    cyc();
    ref_sign = 1'b0;
  endtask

  task automatic digits4(input int a, input int b, input int c, input int d);
    strobe(2'd3, a);
    strobe(2'd2, b);
    strobe(2'd1, c);
    strobe(2'd0, d);
    repeat (3) cyc();
  endtask

  task automatic stick(input int n);
    for (int i = 0; i < n; i++) begin
      scroll_tick = 1'b1;
      cyc();
      scroll_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic set_state(input logic [3:0] s);
    cur_state = s;
    cyc();
    cyc();
  endtask

  // Output is valid two cycles after each strobe; compare against the queued expectation.
  initial begin
    logic [1:0] pipe;
    exp_t e;
    pipe = 2'b00;
    forever begin
      @(negedge clk);
      if (pipe[1]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0d with no expectation queued", char_code);
        end else begin
          e = exp_q.pop_front();
          check("char_code", char_code, e.e1);
          if (e.c2) check("char_code6", char_code6, e.e2);
        end
      end
      pipe = {pipe[0], ref_sign};
    end
  end

  initial begin
    #12;
    check("reset_char", char_code, 36);
    check("reset_active", msg_active, 0);
    check("reset_char6", char_code6, 36);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // LOSE static, plus out-of-range refresh on the 6-digit instance
    set_state(4'd6);
    check("lose_active", msg_active, 1);
    strobe(2'd3, 21, 1'b1, 3'd5, 21);
    strobe(2'd2, 24, 1'b1, 3'd4, 24);
    strobe(2'd1, 28, 1'b1, 3'd3, 28);
    strobe(2'd0, 14, 1'b1, 3'd2, 14);
    strobe(2'd3, 21, 1'b1, 3'd1, 36);
    strobe(2'd3, 21, 1'b1, 3'd6, 36);
    strobe(2'd3, 21, 1'b1, 3'd7, 36);
    repeat (3) cyc();

    // Blink: off after 4 ticks, still off after 7, back on after 8
    stick(4);
    digits4(36, 36, 36, 36);
    stick(3);
    strobe(2'd3, 36, 1'b1, 3'd5, 36);
    repeat (3) cyc();
    stick(1);
    digits4(21, 24, 28, 14);

    // WELCOME scroll
    set_state(4'd0);
    digits4(17, 14, 21, 21);
    stick(1);
    digits4(14, 21, 21, 24);
    stick(5);
    digits4(17, 14, 21, 21);

    // ERROR at offset 3, then state change coincident with tick
    set_state(4'd3);
    stick(3);
    digits4(24, 27, 36, 14);
    cur_state = 4'd5;
    scroll_tick = 1'b1;
    cyc();
    scroll_tick = 1'b0;
    cyc();
    digits4(25, 10, 28, 28);
    set_state(4'd3);
    stick(2);
    cur_state = 4'd0;
    scroll_tick = 1'b1;
    cyc();
    scroll_tick = 1'b0;
    cyc();
    digits4(17, 14, 21, 21);

    // No-message state
    set_state(4'd1);
    check("game_active", msg_active, 0);
    check("game_active6", msg_active6, 0);
    strobe(2'd3, 36, 1'b1, 3'd5, 36);
    strobe(2'd0, 36, 1'b1, 3'd7, 36);
    repeat (3) cyc();

    // Reset mid-scroll of HELLO
    set_state(4'd0);
    stick(2);
    strobe(2'd0, 36);
    strobe(2'd3, 21);
    strobe(2'd2, 21);
    strobe(2'd1, 24);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    check("midreset_char", char_code, 36);
    check("midreset_active", msg_active, 0);
    repeat (2) cyc();
    #3 rst_n = 1'b1;
    cyc();
    digits4(17, 14, 21, 21);
    check("after_reset_active", msg_active, 1);

    repeat (4) cyc();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msg_display.md
MSG_DISPLAY -- requirements
Module: msg_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of scanned display digits (2..8).
REQ-002 SHALL have parameter BLINK_EN, default 1, enables blinking of LOSE and ERROR messages.
REQ-003 SHALL have parameter BLINK_DIV, default 4, number of scroll_tick pulses per blink half-period (1..15).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cur_state  input  4  game state code (WELCOME=0, GAME=1, SCORE=2, ERROR=3, COIN=4, PASS=5, LOSE=6).
REQ-007 SHALL have port ref_sign  input  1  one-cycle digit-scan strobe.
REQ-008 SHALL have port refresh  input  DIG_W  digit index being scanned, DIG_W = clog2(NUM_DIGITS), 0 = rightmost digit.
REQ-009 SHALL have port scroll_tick  input  1  one-cycle slow strobe driving scroll and blink.
REQ-010 SHALL have port char_code  output  6  registered character code for the scanned digit.
REQ-011 SHALL have port msg_active  output  1  registered; high when cur_state has a message.

Function
REQ-012 SHALL use character codes 0-9 for digits, 10-35 for A-Z (E=14, L=21, O=24, S=28) and 36 for BLANK.
REQ-013 SHALL map messages: WELCOME "HELLO", ERROR "ERROR", COIN "COIN", PASS "PASS", LOSE "LOSE"; GAME, SCORE and codes 7-15 have no message.
REQ-014 SHALL, for a message of length L <= NUM_DIGITS, display it static and left-aligned, with unused right digits BLANK.
REQ-015 SHALL, for L > NUM_DIGITS, scroll left one position per scroll_tick over a cyclic sequence of L+1 chars (message followed by one BLANK).
REQ-016 SHALL hold a scroll offset 0..L; the offset increments on scroll_tick and wraps from L to 0.
REQ-017 SHALL show on digit d the char at sequence position (offset + NUM_DIGITS-1-d) mod (L+1).
REQ-018 SHALL register cur_state each cycle; a change in cur_state clears the offset, the blink counter and the blink phase in that cycle.
REQ-019 SHALL give a cur_state change priority over a simultaneous scroll_tick, leaving offset 0.
REQ-020 SHALL update an internal char register only on cycles with ref_sign high, using the current cur_state, refresh and offset; otherwise it holds.
REQ-021 SHALL copy the internal char register to char_code one cycle later, giving 2-cycle latency from ref_sign to char_code.
REQ-022 SHALL, with BLINK_EN=1 in ERROR or LOSE, toggle a blink phase after every BLINK_DIV scroll_ticks; while the phase is off, the lookup yields BLANK.
REQ-023 SHALL, when cur_state has no message, load BLANK on ref_sign and drive msg_active low.
REQ-024 SHALL treat a refresh value >= NUM_DIGITS as BLANK.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set char_code and the internal char register to BLANK (36), msg_active to 0, and the offset, blink counter and blink phase (on) to 0.
REQ-026 SHALL resume normally on the first clk edge after rst_n deasserts; reset mid-scroll restarts at offset 0.

Structure
REQ-027 SHALL place state codes, character codes (including BLANK) and message strings and lengths in a shared package msg_pkg.
REQ-028 SHALL implement the combinational message/position-to-char lookup as sub-module msg_rom.

Verification
REQ-029 SHALL cover: reset, then LOSE with ref_sign at refresh 3,2,1,0 -> char_code 21,24,28,14, each 2 cycles after its strobe.
REQ-030 SHALL cover: WELCOME, refresh 3..0 at offset 0 -> 17,14,21,21; after one scroll_tick -> 14,21,21,24; after 6 ticks -> offset 0 again.
REQ-031 SHALL cover: LOSE, BLINK_DIV=4, 4 scroll_ticks -> all digits 36; 4 more ticks -> LOSE again.
REQ-032 SHALL cover: ERROR at offset 3, cur_state->PASS coincident with scroll_tick -> offset 0, digits show 25,10,28,28.
REQ-033 SHALL cover: cur_state=GAME with strobes -> char_code 36, msg_active 0; refresh >= NUM_DIGITS -> 36.
REQ-034 SHALL cover: rst_n pulsed low mid-scroll of HELLO -> char_code 36 immediately; after release, offset 0 display 17,14,21,21.
